// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential packed-BCD to binary converter using reverse double-dabble
module bcd2bin_seq #(
  parameter int D = 4,
  parameter int N = 14
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [4*D-1:0] bcd_in,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [N-1:0]   bin_out
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t         r_state, w_next;
  logic [4*D-1:0] r_bcd_sr, w_bcd_sh, w_bcd_nx;
  logic [N-1:0]   r_bin_sr, w_bin_nx, r_bin_out;
  logic [CW-1:0]  r_cnt;
  logic [D-1:0]   w_dig_bad;
  logic           r_done, r_err, w_bad, w_last;
  assign {w_bcd_sh, w_bin_nx} = {1'b0, r_bcd_sr, r_bin_sr[N-1:1]};
  for (genvar g = 0; g < D; g++) begin : g_dig
    assign w_dig_bad[g] = bcd_in[4*g+:4] > 4'd9;
    assign w_bcd_nx[4*g+:4] = w_bcd_sh[4*g+3] ? w_bcd_sh[4*g+:4] - 4'd3 : w_bcd_sh[4*g+:4];
  end
  assign w_bad   = |w_dig_bad;
  assign w_last  = r_cnt == CW'(N - 1);
  assign busy    = r_state == SHIFT;
  assign done    = r_done;
  assign err     = r_err;
  assign bin_out = r_bin_out;
  // next state: accept only valid starts from IDLE, return after the N-th shift
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? ((start && !w_bad) ? SHIFT : IDLE) : (w_last ? IDLE : SHIFT);
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  // datapath: load on start, shift-and-correct while busy, publish on the last shift
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bcd_sr  <= '0;
      r_bin_sr  <= '0;
      r_cnt     <= '0;
      r_bin_out <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (r_state == IDLE) begin
        if (start) begin
          r_bcd_sr <= bcd_in;
          r_bin_sr <= '0;
          r_cnt    <= '0;
          r_done   <= w_bad;
          r_err    <= w_bad;
        end
      end else begin
        r_bcd_sr <= w_bcd_nx;
        r_bin_sr <= w_bin_nx;
        r_cnt    <= r_cnt + 1'b1;
        if (w_last) begin
          r_bin_out <= w_bin_nx;
          r_done    <= 1'b1;
        end
      end
    end
  end
endmodule
